// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream master bundle used by the packet generator.
// Handshake: a beat moves on a rising edge where tvalid and tready are both 1;
// while tvalid=1 and tready=0 the master holds tdata/tstrb/tlast/tuser unchanged,
// and tvalid never drops without a transfer.
interface axis_pkt_gen_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tready;

  modport master (output tdata, output tstrb, output tvalid, output tlast,
                  output tuser, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast,
                  input tuser, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// Ethernet-style test packet generator: two header beats, an incrementing
// payload, optional inter-packet gap, repeated for num_pkts packets or until stop.
module axis_pkt_gen #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_LEN_WIDTH          = 8
) (
  input  logic                   axi_aclk,
  input  logic                   axi_resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [15:0]            num_pkts,
  input  logic [C_LEN_WIDTH-1:0] payload_beats,
  input  logic [C_LEN_WIDTH-1:0] gap_cycles,
  input  logic [47:0]            dst_mac,
  input  logic [47:0]            src_mac,
  input  logic [15:0]            ethertype,
  input  logic [7:0]             src_port,
  input  logic [7:0]             dst_port,
  axis_pkt_gen_if.master         m_axis,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkt_count,
  output logic [2:0]             dbg_state_o
);

  localparam int DW    = C_M_AXIS_DATA_WIDTH;
  localparam int TW    = C_M_AXIS_TUSER_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int LANES = DW / 64;
  localparam logic [C_LEN_WIDTH-1:0] ONE = C_LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t                 state_q;
  logic [15:0]            num_q;
  logic [C_LEN_WIDTH-1:0] beats_q;
  logic [C_LEN_WIDTH-1:0] gap_cfg_q;
  logic [47:0]            dst_q;
  logic [47:0]            src_q;
  logic [15:0]            et_q;
  logic [C_LEN_WIDTH-1:0] beat_q;
  logic [C_LEN_WIDTH-1:0] gap_q;
  logic                   stop_seen_q;
  logic                   busy_q;
  logic                   done_q;
  logic [15:0]            pkt_count_q;
  logic [DW-1:0]          tdata_q;
  logic [BYTES-1:0]       tstrb_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic [TW-1:0]          tuser_q;

  // Replicate one 64-bit header word across every lane of the bus.
  function automatic logic [DW-1:0] lanes(input logic [63:0] v);
    return {LANES{v}};
  endfunction

  // Payload beat k: every byte carries the low byte of the beat index.
  function automatic logic [DW-1:0] pay_pat(input logic [C_LEN_WIDTH-1:0] k);
    return {BYTES{8'(k)}};
  endfunction

  // Sideband: packet length in bytes (16-bit, wraps), source and destination port.
  function automatic logic [TW-1:0] tuser_pat(input logic [C_LEN_WIDTH-1:0] beats,
                                              input logic [7:0] sp,
                                              input logic [7:0] dp);
    logic [TW-1:0] t;
    t = '0;
    t[15:0]  = 16'((32'(beats) + 32'd2) * 32'(BYTES));
    t[23:16] = sp;
    t[31:24] = dp;
    return t;
  endfunction

  logic          fire_d;
  logic [15:0]   pkt_count_d;
  logic          end_at_tlast_d;
  logic          end_in_gap_d;
  logic [DW-1:0] hdr0_d;
  logic [DW-1:0] hdr1_d;

  // Run-termination decisions: a tlast with no gap decides on the incremented
  // count; the end of a gap decides on the count already stored.
  assign fire_d         = tvalid_q & m_axis.tready;
  assign pkt_count_d    = pkt_count_q + 16'd1;
  assign end_at_tlast_d = ((num_q != 16'd0) && (pkt_count_d == num_q)) || stop_seen_q || stop;
  assign end_in_gap_d   = ((num_q != 16'd0) && (pkt_count_q == num_q)) || stop_seen_q || stop;
  assign hdr0_d         = lanes({src_q[15:0], dst_q});
  assign hdr1_d         = lanes({16'h0000, et_q, src_q[47:16]});

  // Packet FSM with all stream and status outputs registered.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      beats_q     <= '0;
      gap_cfg_q   <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      et_q        <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      stop_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pkt_count_q <= '0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && stop) stop_seen_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q       <= num_pkts;
            beats_q     <= payload_beats;
            gap_cfg_q   <= gap_cycles;
            dst_q       <= dst_mac;
            src_q       <= src_mac;
            et_q        <= ethertype;
            beat_q      <= '0;
            gap_q       <= '0;
            stop_seen_q <= 1'b0;
            busy_q      <= 1'b1;
            pkt_count_q <= '0;
            state_q     <= S_HDR0;
            tvalid_q    <= 1'b1;
            tstrb_q     <= '1;
            tlast_q     <= 1'b0;
            tdata_q     <= lanes({src_mac[15:0], dst_mac});
            tuser_q     <= tuser_pat(payload_beats, src_port, dst_port);
          end
        end
        S_HDR0: begin
          if (fire_d) begin
            state_q <= S_HDR1;
            tdata_q <= hdr1_d;
            tlast_q <= (beats_q == '0);
          end
        end
        S_HDR1, S_PAYLOAD: begin
          if (fire_d) begin
            if (tlast_q) begin
              pkt_count_q <= pkt_count_d;
              beat_q      <= '0;
              if (gap_cfg_q != '0) begin
                state_q  <= S_GAP;
                gap_q    <= '0;
                tvalid_q <= 1'b0;
                tstrb_q  <= '0;
                tlast_q  <= 1'b0;
                tdata_q  <= '0;
              end else if (end_at_tlast_d) begin
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                tvalid_q <= 1'b0;
                tstrb_q  <= '0;
                tlast_q  <= 1'b0;
                tdata_q  <= '0;
                tuser_q  <= '0;
              end else begin
                state_q <= S_HDR0;
                tlast_q <= 1'b0;
                tdata_q <= hdr0_d;
              end
            end else if (state_q == S_HDR1) begin
              state_q <= S_PAYLOAD;
              beat_q  <= '0;
              tdata_q <= pay_pat('0);
              tlast_q <= (beats_q == ONE);
            end else begin
              beat_q  <= beat_q + ONE;
              tdata_q <= pay_pat(beat_q + ONE);
              tlast_q <= ((beat_q + ONE) == (beats_q - ONE));
            end
          end
        end
        S_GAP: begin
          if (gap_q == (gap_cfg_q - ONE)) begin
            gap_q <= '0;
            if (end_in_gap_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              tuser_q <= '0;
            end else begin
              state_q  <= S_HDR0;
              tvalid_q <= 1'b1;
              tstrb_q  <= '1;
              tdata_q  <= hdr0_d;
            end
          end else begin
            gap_q <= gap_q + ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tstrb  = tstrb_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = pkt_count_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: scoreboard of expected beats checked by a
// free-running monitor, plus directed status, reset and header-layout checks.
module tb_axis_pkt_gen;

  localparam int DW = 256;
  localparam int TU = 128;
  localparam int SW = DW / 8;
  localparam int EW = 1 + TU + DW;
  localparam logic [63:0] H0 = 64'hAABB_0011_2233_4455;
  localparam logic [63:0] H1 = 64'h0000_88B5_6677_8899;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic axi_resetn;
  always #5 clk = ~clk;

  logic        start, stop, start64;
  logic [15:0] num_pkts;
  logic [7:0]  payload_beats, gap_cycles;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype;
  logic [7:0]  src_port, dst_port;
  logic        busy, done, busy64, done64;
  logic [15:0] pkt_count, pkt64;
  logic [2:0]  dbg_state, dbg64;
  logic        rand_mode;

  axis_pkt_gen_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TU)) axis ();
  axis_pkt_gen_if #(.DATA_WIDTH(64), .TUSER_WIDTH(TU)) axis64 ();

  axis_pkt_gen #(.C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(TU), .C_LEN_WIDTH(8)) dut (
    .axi_aclk(clk), .axi_resetn(axi_resetn), .start(start), .stop(stop),
    .num_pkts(num_pkts), .payload_beats(payload_beats), .gap_cycles(gap_cycles),
    .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .src_port(src_port), .dst_port(dst_port), .m_axis(axis),
    .busy(busy), .done(done), .pkt_count(pkt_count), .dbg_state_o(dbg_state)
  );

  axis_pkt_gen #(.C_M_AXIS_DATA_WIDTH(64), .C_M_AXIS_TUSER_WIDTH(TU), .C_LEN_WIDTH(8)) dut64 (
    .axi_aclk(clk), .axi_resetn(axi_resetn), .start(start64), .stop(1'b0),
    .num_pkts(16'd1), .payload_beats(8'd0), .gap_cycles(8'd0),
    .dst_mac(48'hCAFECAFECAFE), .src_mac(48'hBEEFBEEFBEEF), .ethertype(16'h0800),
    .src_port(8'h00), .dst_port(8'h00), .m_axis(axis64),
    .busy(busy64), .done(done64), .pkt_count(pkt64), .dbg_state_o(dbg64)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int valid_samples = 0;
  int busy_samples  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input logic [15:0] n, input logic [7:0] b, input logic [7:0] g);
    num_pkts      = n;
    payload_beats = b;
    gap_cycles    = g;
    dst_mac       = 48'h0011_2233_4455;
    src_mac       = 48'h6677_8899_AABB;
    ethertype     = 16'h88B5;
    src_port      = 8'h12;
    dst_port      = 8'h34;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Expected beats for one packet; len is the hand-computed byte count.
  task automatic push_pkt(input int beats, input logic [15:0] len);
    logic [TU-1:0] tu;
    logic [7:0]    b;
    tu = {96'h0, 8'h34, 8'h12, len};
    exp_q.push_back({1'b0, tu, {4{H0}}});
    exp_q.push_back({(beats == 0), tu, {4{H1}}});
    for (int k = 0; k < beats; k++) begin
      b = k[7:0];
      exp_q.push_back({(k == beats - 1), tu, {32{b}}});
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s: busy still %0d after %0d cycles, want 0", name, busy, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int i;
    i = 0;
    while (xfer_cnt < target && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    total++;
    if (xfer_cnt < target) begin
      bad++;
      $display("FAIL wait_xfers: got %0d transfers want %0d", xfer_cnt, target);
    end
  endtask

  // ---------------- tready generator ----------------
  initial begin
    axis.tready   = 1'b1;
    axis64.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      axis.tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor: transfers, stall stability, strobes ----------------
  logic [EW+SW:0] prev_bus, cur_bus;
  logic           prev_stall = 1'b0;
  logic [EW-1:0]  act, expv;

  always @(negedge clk) begin
    cur_bus = {axis.tvalid, axis.tlast, axis.tuser, axis.tdata, axis.tstrb};
    if (axi_resetn) begin
      if (busy) busy_samples++;
      if (axis.tvalid) valid_samples++;
      if (done) done_cnt++;
      if (prev_stall) begin
        total++;
        if (cur_bus !== prev_bus) begin
          bad++;
          $display("FAIL stall_stable: got %0h want %0h", cur_bus, prev_bus);
        end
      end
      total++;
      if (axis.tstrb !== (axis.tvalid ? {SW{1'b1}} : {SW{1'b0}})) begin
        bad++;
        $display("FAIL tstrb: got %0h with tvalid %0d", axis.tstrb, axis.tvalid);
      end
      if (axis.tvalid && axis.tready) begin
        xfer_cnt++;
        total++;
        act = {axis.tlast, axis.tuser, axis.tdata};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got %0h want none", act);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            bad++;
            $display("FAIL beat_%0d: got %0h want %0h", xfer_cnt, act, expv);
          end
        end
      end
      prev_stall = axis.tvalid && !axis.tready;
    end else begin
      prev_stall = 1'b0;
    end
    prev_bus = cur_bus;
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int d0, base;

  initial begin
    axi_resetn = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    start64    = 1'b0;
    rand_mode  = 1'b0;
    set_cfg(16'd1, 8'd14, 8'd128);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("rst_tlast", 64'(axis.tlast), 64'd0);
    chk("rst_tdata_nonzero", 64'(axis.tdata != '0), 64'd0);
    chk("rst_tstrb", 64'(axis.tstrb), 64'd0);
    chk("rst_tuser_nonzero", 64'(axis.tuser != '0), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1 axi_resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Long packet, full throughput; mid-run config change and start are ignored.
    set_cfg(16'd1, 8'd14, 8'd128);
    push_pkt(14, 16'h0200);
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("start_latency_tvalid", 64'(axis.tvalid), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    chk("hdr0_lane0", axis.tdata[63:0], H0);
    dst_mac = 48'hFFFF_FFFF_FFFF;
    payload_beats = 8'd3;
    repeat (3) @(posedge clk);
    pulse_start();
    wait_idle(400, "t1_idle");
    chk("t1_pkt_count", 64'(pkt_count), 64'd1);
    chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t1_queue_left", 64'(exp_q.size()), 64'd0);
    chk("t1_tvalid_idle", 64'(axis.tvalid), 64'd0);

    // Same packet with random backpressure.
    rand_mode = 1'b1;
    set_cfg(16'd1, 8'd14, 8'd128);
    push_pkt(14, 16'h0200);
    d0 = done_cnt;
    pulse_start();
    wait_idle(800, "t2_idle");
    rand_mode = 1'b0;
    chk("t2_pkt_count", 64'(pkt_count), 64'd1);
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t2_queue_left", 64'(exp_q.size()), 64'd0);

    // Header-only packets back to back.
    set_cfg(16'd3, 8'd0, 8'd0);
    for (int p = 0; p < 3; p++) push_pkt(0, 16'h0040);
    d0 = done_cnt;
    valid_samples = 0;
    busy_samples  = 0;
    pulse_start();
    wait_idle(100, "t3_idle");
    chk("t3_valid_cycles", 64'(valid_samples), 64'd6);
    chk("t3_busy_cycles", 64'(busy_samples), 64'd6);
    chk("t3_pkt_count", 64'(pkt_count), 64'd3);
    chk("t3_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t3_queue_left", 64'(exp_q.size()), 64'd0);

    // Unlimited run stopped during packet 5.
    set_cfg(16'd0, 8'd2, 8'd3);
    for (int p = 0; p < 5; p++) push_pkt(2, 16'h0080);
    d0 = done_cnt;
    base = xfer_cnt;
    pulse_start();
    wait_xfers(base + 17, 300);
    stop = 1'b1;
    repeat (2) @(posedge clk);
    #1 stop = 1'b0;
    wait_idle(300, "t4_idle");
    repeat (10) @(negedge clk);
    chk("t4_pkt_count", 64'(pkt_count), 64'd5);
    chk("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t4_queue_left", 64'(exp_q.size()), 64'd0);
    chk("t4_busy_after", 64'(busy), 64'd0);

    // Reset while presenting payload beat 3, then restart.
    set_cfg(16'd1, 8'd8, 8'd0);
    push_pkt(8, 16'h0140);
    base = xfer_cnt;
    pulse_start();
    wait_xfers(base + 5, 100);
    axi_resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("t5_rst_tlast", 64'(axis.tlast), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("t5_beats_left", 64'(exp_q.size()), 64'd5);
    exp_q.delete();
    @(posedge clk); #1 axi_resetn = 1'b1;
    set_cfg(16'd1, 8'd1, 8'd0);
    push_pkt(1, 16'h0060);
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("t5_restart_hdr0", axis.tdata[63:0], H0);
    wait_idle(100, "t5_idle");
    chk("t5_pkt_count", 64'(pkt_count), 64'd1);
    chk("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t5_queue_left", 64'(exp_q.size()), 64'd0);

    // 64-bit bus header layout.
    @(posedge clk); #1 start64 = 1'b1;
    @(posedge clk); #1 start64 = 1'b0;
    @(negedge clk);
    chk("w64_hdr0", axis64.tdata, 64'hBEEFCAFECAFECAFE);
    chk("w64_hdr0_tlast", 64'(axis64.tlast), 64'd0);
    chk("w64_tuser_len", 64'(axis64.tuser[15:0]), 64'd16);
    @(negedge clk);
    chk("w64_hdr1", axis64.tdata, 64'h00000800BEEFBEEF);
    chk("w64_hdr1_tlast", 64'(axis64.tlast), 64'd1);
    repeat (3) @(negedge clk);
    chk("w64_busy", 64'(busy64), 64'd0);
    chk("w64_pkt_count", 64'(pkt64), 64'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
